// File: rtl/display_pkg.sv
// Shared types, constants and sign/magnitude helper
// for the signed display arbiter.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int DWELL_1S  = 50000000;
  localparam int DWELL_SIM = 4;

  // Two's complement byte to {neg, magnitude}.
  // -128 wraps to 0x80, which is exactly its magnitude.
  function automatic logic [8:0] sign_mag(input logic [7:0] v);
    logic [7:0] m;
    m = v[7] ? (~v + 8'd1) : v;
    return {v[7], m};
  endfunction

endpackage

// File: rtl/signed_display_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req bit
// strictly after last, wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [2:0]       i_last,
  output logic [2:0]       o_winner,
  output logic             o_any
);

  localparam logic [N_REQ-1:0] LP_ONE =
    {{(N_REQ-1){1'b0}}, 1'b1};

  assign o_any = |i_req;

  // scan last+1 .. last+N_REQ with wrap, keep first hit
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    o_winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(i_last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && ((i_req >> idx) & LP_ONE) != '0) begin
        found    = 1'b1;
        o_winner = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/signed_display_arbiter.sv
// Round-robin arbiter sharing one signed 2-digit display.
// Define DISPLAY_LIVE_UPDATE_EN to track data live in SHOW.
module signed_display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DWELL = DWELL_1S,
  parameter int CW    = 26
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_data,
  output logic [N_REQ-1:0]     o_grant,
  output logic [2:0]           o_owner,
  output logic                 o_valid,
  output logic [7:0]           o_magnitude,
  output logic                 o_neg
);

  localparam logic [CW-1:0] LP_LAST = CW'(DWELL - 1);
  localparam logic [N_REQ-1:0] LP_ONE =
    {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_last;
  logic [N_REQ-1:0] r_grant;
  logic [2:0]       r_owner;
  logic             r_valid;
  logic [7:0]       r_mag;
  logic             r_neg;

  logic [2:0]       w_win;
  logic             w_any;
  logic [7:0]       w_win_data;
  logic [7:0]       w_own_data;
  logic             w_own_req;
  logic             w_others;
  logic             w_expire;
  logic             w_do_grant;
  logic             w_drop;
  logic             w_restart;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_winner (w_win),
    .o_any    (w_any)
  );

  // in SHOW, r_grant is the owner's one-hot bit
  assign w_own_req = |(i_req & r_grant);
  assign w_others  = |(i_req & ~r_grant);
  assign w_expire  = (r_cnt == LP_LAST);

  // byte lanes for the winner and the current owner
  always_comb begin
    w_win_data = '0;
    w_own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == i[2:0])   w_win_data = i_data[8*i +: 8];
      if (r_owner == i[2:0]) w_own_data = i_data[8*i +: 8];
    end
  end

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next state; owner drop outranks dwell expiry
  always_comb begin
    w_next     = r_state;
    w_do_grant = 1'b0;
    w_drop     = 1'b0;
    w_restart  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_next = GRANT;
      end
      GRANT: begin
        if (w_any) begin
          w_next     = SHOW;
          w_do_grant = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      SHOW: begin
        if (!w_own_req) begin
          w_next = w_others ? GRANT : IDLE;
          w_drop = 1'b1;
        end else if (w_expire) begin
          if (w_others) begin
            w_next = GRANT;
            w_drop = 1'b1;
          end else begin
            w_restart = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // grant, dwell counter and snapshot registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_last  <= 3'(N_REQ - 1);
      r_grant <= '0;
      r_owner <= '0;
      r_valid <= 1'b0;
      r_mag   <= '0;
      r_neg   <= 1'b0;
    end else if (w_do_grant) begin
      r_cnt            <= '0;
      r_last           <= w_win;
      r_grant          <= LP_ONE << w_win;
      r_owner          <= w_win;
      r_valid          <= 1'b1;
      {r_neg, r_mag}   <= sign_mag(w_win_data);
    end else if (w_drop) begin
      r_cnt   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else if (w_restart) begin
      r_cnt          <= '0;
      {r_neg, r_mag} <= sign_mag(w_own_data);
    end else if (r_state == SHOW) begin
      r_cnt <= r_cnt + 1'b1;
`ifdef DISPLAY_LIVE_UPDATE_EN
      {r_neg, r_mag} <= sign_mag(w_own_data);
`endif
    end
  end

  assign o_grant     = r_grant;
  assign o_owner     = r_owner;
  assign o_valid     = r_valid;
  assign o_magnitude = r_mag;
  assign o_neg       = r_neg;

endmodule

// File: tb/tb_signed_display_arbiter.sv
// Directed bench for signed_display_arbiter, DWELL=4, N_REQ=4.
// Honours DISPLAY_LIVE_UPDATE_EN for the snapshot expectations.
module tb_signed_display_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   grant;
  logic [2:0]     owner;
  logic           valid;
  logic [7:0]     mag;
  logic           neg;

  int n_vec = 0;
  int n_err = 0;

  signed_display_arbiter #(
    .N_REQ (N),
    .DWELL (4),
    .CW    (3)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_data      (data),
    .o_grant     (grant),
    .o_owner     (owner),
    .o_valid     (valid),
    .o_magnitude (mag),
    .o_neg       (neg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [3:0] g,
                         input logic [2:0] o,
                         input logic v,
                         input logic [7:0] m,
                         input logic n);
    chk(tag, {grant, owner, valid, mag, neg},
        {g, o, v, m, n});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int   t;
    int   k;
    int   cnt [N];
    logic [N-1:0] pg;
    logic [7:0] e_mag;
    logic       e_neg;

    rst  = 1'b1;
    req  = '0;
    data = '0;
    tick();
    tick();
    chk_all("reset", 4'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // two requesters alternate: 0 then 2 then 0
    data[7:0]   = 8'h05;
    data[23:16] = 8'hFB;
    req = 4'b0101;
    tick();
    chk("lat_e1_valid", valid, 1'b0);
    tick();
    chk_all("own0", 4'b0001, 3'd0, 1'b1, 8'h05, 1'b0);
    tick(); tick(); tick();
    chk_all("own0_c4", 4'b0001, 3'd0, 1'b1, 8'h05, 1'b0);
    tick();
    chk("gap_grant", {grant, valid}, 5'b0);
    tick();
    chk_all("own2", 4'b0100, 3'd2, 1'b1, 8'h05, 1'b1);
    tick(); tick(); tick();
    tick();
    chk("gap2_valid", valid, 1'b0);
    tick();
    chk_all("back0", 4'b0001, 3'd0, 1'b1, 8'h05, 1'b0);

    // hand over to requester 1, then async reset mid-SHOW
    req = 4'b0010;
    tick();
    tick();
    chk("own1", {grant, owner}, {4'b0010, 3'd1});
    #2;
    rst = 1'b1;
    req = 4'b0001;
    #1;
    chk_all("async_rst", 4'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_e1", grant, 4'b0);
    tick();
    chk_all("rel_e2", 4'b0001, 3'd0, 1'b1, 8'h05, 1'b0);

    // lone requester 3 with -128, then 0x7F mid-dwell
    data[31:24] = 8'h80;
    req = 4'b1000;
    tick();
    tick();
    chk_all("r3_m128", 4'b1000, 3'd3, 1'b1, 8'h80, 1'b1);
    tick();
    data[31:24] = 8'h7F;
`ifdef DISPLAY_LIVE_UPDATE_EN
    e_mag = 8'h7F; e_neg = 1'b0;
`else
    e_mag = 8'h80; e_neg = 1'b1;
`endif
    tick();
    chk_all("r3_hold_a", 4'b1000, 3'd3, 1'b1, e_mag, e_neg);
    tick();
    chk_all("r3_hold_b", 4'b1000, 3'd3, 1'b1, e_mag, e_neg);
    tick();
    chk_all("r3_restart", 4'b1000, 3'd3, 1'b1, 8'h7F, 1'b0);

    // owner 1 drops in its second SHOW cycle, req2 pending
    req = 4'b0010;
    tick();
    tick();
    chk("own1_b", {grant, owner}, {4'b0010, 3'd1});
    tick();
    req = 4'b0100;
    tick();
    chk("drop_gap", {grant, valid}, 5'b0);
    tick();
    chk("drop_to2", {grant, owner, valid},
        {4'b0100, 3'd2, 1'b1});
    req = 4'b0000;
    tick();
    chk("drop_idle", {grant, valid}, 5'b0);
    tick();
    chk("stay_idle", {grant, valid}, 5'b0);

    // fairness: all four requesting for 16 dwell periods
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    k  = 0;
    t  = 0;
    pg = '0;
    while (k < 16 && t < 200) begin
      tick();
      t++;
      if (!$onehot0(grant)) begin
        n_err++;
        $error("FAIL onehot got=%0h exp=onehot0", grant);
      end
      if (pg == '0 && grant != '0) begin
        chk("rr_order", {29'd0, owner}, k % 4);
        cnt[owner]++;
        k++;
      end
      pg = grant;
    end
    chk("rr_grants", k, 16);
    chk("rr_ticks", t, 77);
    for (int i = 0; i < N; i++)
      chk("rr_count", cnt[i], 4);

    // data step during SHOW: live vs frozen snapshot
    do_reset();
    req = 4'b0001;
    data[7:0] = 8'h01;
    tick();
    tick();
    chk_all("step_pre", 4'b0001, 3'd0, 1'b1, 8'h01, 1'b0);
    data[7:0] = 8'hFF;
    tick();
`ifdef DISPLAY_LIVE_UPDATE_EN
    e_neg = 1'b1;
`else
    e_neg = 1'b0;
`endif
    chk_all("step_post", 4'b0001, 3'd0, 1'b1, 8'h01, e_neg);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/signed_display_arbiter.md
Name: signed_display_arbiter

Overview:
- Shares one signed-magnitude display path (two hex7seg digits plus a sign digit) among N_REQ requesters, each presenting an 8-bit two's-complement value.
- Grants the display round-robin with a fixed dwell time, snapshots the winner's value, and drives magnitude and sign to the downstream display datapath.
- Sits between the DE2-115 input sources (switch banks, counters) and the SSD decode stage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DWELL, 50000000, display cycles per grant (1 s at 50 MHz); must be at least 2.
- CW, 26, dwell counter width; must satisfy 2^CW > DWELL.

Ports:
- Clock  in  1  system clock, CLOCK_50 domain.
- Reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester display request, level-sensitive.
- data  in  8*N_REQ  requester i value on data[8i+7:8i], two's complement.
- grant  out  N_REQ  one-hot grant, or all zeros.
- owner  out  3  index of the current grantee.
- valid  out  1  display shows a granted value; when low, the display stage blanks all three SSDs.
- magnitude  out  8  absolute value of the snapshot, 0..128.
- neg  out  1  snapshot is negative; drives the minus segment on HEX2.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - grant=0, owner=0, valid=0, magnitude=0, neg=0, dwell counter=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: valid=0, grant=0. If any req is high, go to GRANT on the next edge.
  - GRANT (1 cycle):
    - Pick the first requester with req high, searching (last+1) mod N_REQ upward with wrap.
    - Set grant, owner and last to the winner.
    - Snapshot data[winner], clear the counter, go to SHOW.
    - If req has already dropped to zero, return to IDLE with no grant.
  - SHOW:
    - valid=1; the counter increments each cycle.
    - If req[owner] falls, leave at the next edge: go to GRANT if other requests are pending, else IDLE. grant clears on the same edge.
    - When counter==DWELL-1:
      - Other requests pending: go to GRANT, so the next requester in rotation wins.
      - Only the owner still requesting: stay in SHOW, clear the counter and re-snapshot data.
      - No requests: go to IDLE.
- Snapshot rule:
  - value = data[owner] latched at the GRANT edge, and re-latched on a dwell restart.
  - neg = value[7].
  - magnitude = (~value)+1 when neg, else value, computed 9 bits wide and truncated to 8.
  - -128 (0x80) gives magnitude 0x80 (decimal 128, shown as hex 80) with neg=1.
  - 0 gives neg=0.
- Latency:
  - req rising in IDLE gives grant and valid two edges later.
  - The first SHOW cycle outputs the snapshot registered in GRANT.
- grant is always one-hot or zero, and is never asserted to a requester whose req was low at the GRANT edge.
- Simultaneous owner req-drop and dwell expiry: the req-drop rule takes precedence.
- Outputs are registered; no combinational path from req or data to the outputs.

Optional Feature:
- Macro: DISPLAY_LIVE_UPDATE_EN.
- Defined: in SHOW, value re-latches data[owner] every cycle, so the display tracks the live input. Grant timing is unchanged.
- Undefined: value is frozen at the GRANT edge and at dwell restarts only.

Decomposition:
- Shared package display_pkg:
  - State enum (IDLE, GRANT, SHOW).
  - Default DWELL constants: DWELL_1S=50000000, DWELL_SIM=4.
  - Sign/magnitude function (8-bit two's complement to {neg, magnitude[7:0]}).
- One sub-module rr_pick: combinational round-robin priority encoder, inputs req and last, outputs winner index and any-request flag.
- The FSM, counter and snapshot registers stay in the top.

Test Plan (DWELL=4, N_REQ=4):
- Reset mid-SHOW with grant=0010 → all outputs go to zero on the same cycle. After release with req=0001, grant=0001 two edges later.
- req=0101, data0=0x05, data2=0xFB:
  - Owner 0 first, magnitude=5, neg=0, valid for 4 cycles.
  - Then owner 2, magnitude=5, neg=1.
  - Then back to owner 0.
- Single requester 3 holding req, data3=0x80 → continuous SHOW, grant never drops, magnitude=0x80, neg=1. Change data3 to 0x7F mid-dwell → display updates only at the dwell restart (macro off).
- Owner 1 drops req in its second SHOW cycle with req2 high → grant=0100 two edges later. With no other requests pending → IDLE and valid=0.
- req=1111 held for 16 dwell periods → owners cycle 0,1,2,3 in order, each granted exactly 4 times.
- DISPLAY_LIVE_UPDATE_EN defined: data0 steps 0x01→0xFF during SHOW → magnitude=1, neg=1 one edge after the change.
